// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the registered scanning multiplexer.
// Holds FSM states, mode encodings and the inhibit-value helper.
package scan_mux_pkg;

   typedef enum logic {S_MAN = 1'b0, S_SCAN = 1'b1} state_t;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;
   localparam int   MAX_DW    = 64;

   // All-ones for an inverting mux, all-zeros otherwise; caller keeps the low dw bits.
   function automatic logic [MAX_DW-1:0] inh_val(input int inv, input int dw);
      logic [MAX_DW-1:0] v;
      v = '0;
      if (inv != 0) begin
         for (int b = 0; b < MAX_DW; b++) begin
            if (b < dw) v[b] = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/scan_mux_ctr.sv
// Scan sequencer: dwell counter plus channel counter that wraps at N_CH-1
// and flags each completed sweep with a one-cycle pulse.
module scan_mux_ctr
   import scan_mux_pkg::*;
#(
   parameter int N_CH  = 16,
   parameter int DWELL = 4,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [SEL_W-1:0] load_val,
   output logic [SEL_W-1:0] ch,
   output logic             sweep_done
);

   localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [DC_W-1:0] dwell;
   logic            last_dwell;
   logic            last_ch;

   assign last_dwell = (dwell == DC_W'(DWELL - 1));
   assign last_ch    = (ch == SEL_W'(N_CH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell      <= '0;
         ch         <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         if (load) begin
            dwell <= '0;
            ch    <= load_val;
         end else if (en) begin
            if (last_dwell) begin
               dwell <= '0;
               if (last_ch) begin
                  ch         <= '0;
                  sweep_done <= 1'b1;
               end else begin
                  ch <= ch + SEL_W'(1);
               end
            end else begin
               dwell <= dwell + DC_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel selector with optional inversion, inhibit and an
// auto-scan mode that sweeps every channel with a fixed dwell.
module scan_mux_reg
   import scan_mux_pkg::*;
#(
   parameter int  N_CH  = 16,
   parameter int  DW    = 1,
   parameter int  DWELL = 4,
   parameter int  INV   = 1,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i,
   input  logic               mode,
   input  logic [SEL_W-1:0]   s,
   input  logic [N_CH*DW-1:0] e,
   output logic [DW-1:0]      y,
   output logic               y_vld,
   output logic [SEL_W-1:0]   ch_o,
   output logic               sweep_done
);

   localparam logic [MAX_DW-1:0] INH_FULL = inh_val(INV, DW);
   localparam logic [DW-1:0]     INH      = INH_FULL[DW-1:0];

   state_t           st;
   logic [SEL_W-1:0] scan_ch;
   logic [SEL_W-1:0] eff_ch;
   logic [SEL_W-1:0] load_val;
   logic             s_ok;
   logic             load;
   logic             en;
   logic             blank;
   logic [DW-1:0]    ch_data;

   // s is compared one bit wider since N_CH may equal 2**SEL_W.
   assign s_ok     = ({1'b0, s} < (SEL_W + 1)'(N_CH));
   assign load     = (st == S_MAN) && (mode == MODE_SCAN);
   assign en       = (st == S_SCAN) && !i;
   assign load_val = s_ok ? s : '0;
   assign eff_ch   = (st == S_SCAN) ? scan_ch : s;
   assign blank    = i || ((st == S_MAN) && !s_ok);

   always_comb begin
      ch_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (eff_ch == SEL_W'(k)) ch_data = e[k*DW +: DW];
      end
   end

   scan_mux_ctr #(
      .N_CH  (N_CH),
      .DWELL (DWELL),
      .SEL_W (SEL_W)
   ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .load_val   (load_val),
      .ch         (scan_ch),
      .sweep_done (sweep_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= S_MAN;
         y     <= INH;
         y_vld <= 1'b0;
         ch_o  <= '0;
      end else begin
         st <= (mode == MODE_SCAN) ? S_SCAN : S_MAN;
         if (blank) begin
            y     <= INH;
            y_vld <= 1'b0;
         end else begin
            y     <= (INV != 0) ? ~ch_data : ch_data;
            y_vld <= 1'b1;
            ch_o  <= eff_ch;
         end
      end
   end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed bench for scan_mux_reg: a 16x1 inverting instance (DWELL=4) and
// a 10x4 non-inverting instance (DWELL=1).
module tb_scan_mux_reg;

   logic        clk = 1'b0;
   int          ncheck = 0;
   int          npass  = 0;

   logic        rst_a, i_a, mode_a;
   logic [3:0]  s_a;
   logic [15:0] e_a;
   logic        y_a, vld_a, sd_a;
   logic [3:0]  ch_a;

   logic        rst_b, i_b, mode_b;
   logic [3:0]  s_b;
   logic [39:0] e_b;
   logic [3:0]  y_b, ch_b;
   logic        vld_b, sd_b;

   always #5 clk = ~clk;

   scan_mux_reg #(.N_CH(16), .DW(1), .DWELL(4), .INV(1)) dut_a (
      .clk(clk), .rst(rst_a), .i(i_a), .mode(mode_a), .s(s_a), .e(e_a),
      .y(y_a), .y_vld(vld_a), .ch_o(ch_a), .sweep_done(sd_a));

   scan_mux_reg #(.N_CH(10), .DW(4), .DWELL(1), .INV(0)) dut_b (
      .clk(clk), .rst(rst_b), .i(i_b), .mode(mode_b), .s(s_b), .e(e_b),
      .y(y_b), .y_vld(vld_b), .ch_o(ch_b), .sweep_done(sd_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; i_a = 1'b0; mode_a = 1'b0; s_a = '0; e_a = '0;
      rst_b = 1'b1; i_b = 1'b0; mode_b = 1'b0; s_b = '0; e_b = '0;
      tick(); tick();
      ncheck++; if (y_a !== 1'b1) $display("FAIL reset_y_a got %b want 1", y_a); else npass++;
      ncheck++; if (vld_a !== 1'b0) $display("FAIL reset_vld_a got %b want 0", vld_a); else npass++;
      ncheck++; if (ch_a !== 4'd0) $display("FAIL reset_ch_a got %0d want 0", ch_a); else npass++;
      ncheck++; if (sd_a !== 1'b0) $display("FAIL reset_sd_a got %b want 0", sd_a); else npass++;
      ncheck++; if (y_b !== 4'h0) $display("FAIL reset_y_b got %h want 0", y_b); else npass++;
      ncheck++; if (vld_b !== 1'b0) $display("FAIL reset_vld_b got %b want 0", vld_b); else npass++;
      rst_a = 1'b0; rst_b = 1'b0;
   endtask

   task automatic test_manual();
      for (int k = 0; k < 16; k++) begin
         s_a = 4'(k); e_a = 16'(1 << k);
         tick();
         ncheck++; if (y_a !== 1'b0) $display("FAIL manual_hot_y k=%0d got %b want 0", k, y_a); else npass++;
         ncheck++; if (vld_a !== 1'b1) $display("FAIL manual_hot_vld k=%0d got %b want 1", k, vld_a); else npass++;
         ncheck++; if (ch_a !== 4'(k)) $display("FAIL manual_hot_ch got %0d want %0d", ch_a, k); else npass++;
         e_a = ~16'(1 << k);
         tick();
         ncheck++; if (y_a !== 1'b1) $display("FAIL manual_cold_y k=%0d got %b want 1", k, y_a); else npass++;
      end
   endtask

   task automatic test_inhibit();
      s_a = 4'd3; e_a = 16'h0000; i_a = 1'b1;
      tick();
      ncheck++; if (y_a !== 1'b1) $display("FAIL inhibit_y got %b want 1", y_a); else npass++;
      ncheck++; if (vld_a !== 1'b0) $display("FAIL inhibit_vld got %b want 0", vld_a); else npass++;
      ncheck++; if (ch_a !== 4'd15) $display("FAIL inhibit_ch_hold got %0d want 15", ch_a); else npass++;
      i_a = 1'b0;
      tick();
      ncheck++; if (y_a !== 1'b1) $display("FAIL release_y got %b want 1", y_a); else npass++;
      ncheck++; if (vld_a !== 1'b1) $display("FAIL release_vld got %b want 1", vld_a); else npass++;
      ncheck++; if (ch_a !== 4'd3) $display("FAIL release_ch got %0d want 3", ch_a); else npass++;
   endtask

   task automatic test_scan();
      int ech;
      logic esd;
      e_a = 16'h5555; s_a = 4'd0; mode_a = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         tick();
         ech = ((c - 2) / 4) % 16;
         esd = (c == 65);
         ncheck++; if (ch_a !== 4'(ech)) $display("FAIL scan_ch cyc=%0d got %0d want %0d", c, ch_a, ech); else npass++;
         ncheck++; if (y_a !== ech[0]) $display("FAIL scan_y cyc=%0d got %b want %b", c, y_a, ech[0]); else npass++;
         ncheck++; if (sd_a !== esd) $display("FAIL scan_sd cyc=%0d got %b want %b", c, sd_a, esd); else npass++;
      end
   endtask

   task automatic test_freeze();
      int ech;
      logic inh, esd;
      mode_a = 1'b0;
      tick();
      s_a = 4'd5; mode_a = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (c == 3) i_a = 1'b1;
         if (c == 13) i_a = 1'b0;
         inh = (c >= 4 && c <= 13);
         ech = (c <= 15) ? 5 : (6 + (c - 16) / 4) % 16;
         esd = (c == 55);
         ncheck++; if (ch_a !== 4'(ech)) $display("FAIL freeze_ch cyc=%0d got %0d want %0d", c, ch_a, ech); else npass++;
         ncheck++; if (vld_a !== !inh) $display("FAIL freeze_vld cyc=%0d got %b want %b", c, vld_a, !inh); else npass++;
         ncheck++; if (y_a !== (inh ? 1'b1 : ech[0])) $display("FAIL freeze_y cyc=%0d got %b", c, y_a); else npass++;
         ncheck++; if (sd_a !== esd) $display("FAIL freeze_sd cyc=%0d got %b want %b", c, sd_a, esd); else npass++;
      end
   endtask

   task automatic test_async_reset();
      int ech;
      @(posedge clk);
      #3 rst_a = 1'b1;
      #1;
      ncheck++; if (y_a !== 1'b1) $display("FAIL areset_y got %b want 1", y_a); else npass++;
      ncheck++; if (vld_a !== 1'b0) $display("FAIL areset_vld got %b want 0", vld_a); else npass++;
      ncheck++; if (ch_a !== 4'd0) $display("FAIL areset_ch got %0d want 0", ch_a); else npass++;
      #2 rst_a = 1'b0; s_a = 4'd0; mode_a = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         ech = ((c - 2) / 4) % 16;
         ncheck++; if (ch_a !== 4'(ech)) $display("FAIL areset_scan_ch cyc=%0d got %0d want %0d", c, ch_a, ech); else npass++;
      end
      mode_a = 1'b0;
   endtask

   task automatic test_b_manual();
      e_b = 40'hA987654321;
      s_b = 4'd7;
      tick();
      ncheck++; if (y_b !== 4'h8) $display("FAIL b_sel7_y got %h want 8", y_b); else npass++;
      ncheck++; if (ch_b !== 4'd7) $display("FAIL b_sel7_ch got %0d want 7", ch_b); else npass++;
      s_b = 4'd12;
      tick();
      ncheck++; if (y_b !== 4'h0) $display("FAIL b_oor_y got %h want 0", y_b); else npass++;
      ncheck++; if (vld_b !== 1'b0) $display("FAIL b_oor_vld got %b want 0", vld_b); else npass++;
      ncheck++; if (ch_b !== 4'd7) $display("FAIL b_oor_ch got %0d want 7", ch_b); else npass++;
   endtask

   task automatic test_b_mode_inhibit();
      s_b = 4'd3; mode_b = 1'b1; i_b = 1'b1;
      tick();
      ncheck++; if (vld_b !== 1'b0) $display("FAIL b_modeinh_vld got %b want 0", vld_b); else npass++;
      ncheck++; if (y_b !== 4'h0) $display("FAIL b_modeinh_y got %h want 0", y_b); else npass++;
      i_b = 1'b0;
      tick();
      ncheck++; if (ch_b !== 4'd3) $display("FAIL b_modeinh_ch1 got %0d want 3", ch_b); else npass++;
      ncheck++; if (y_b !== 4'h4) $display("FAIL b_modeinh_y1 got %h want 4", y_b); else npass++;
      tick();
      ncheck++; if (ch_b !== 4'd4) $display("FAIL b_modeinh_ch2 got %0d want 4", ch_b); else npass++;
      mode_b = 1'b0;
      tick();
   endtask

   task automatic test_b_scan();
      int ech;
      logic esd;
      s_b = 4'd0; mode_b = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         ech = (c <= 2) ? 0 : (c - 2) % 10;
         esd = (c == 11) || (c == 21);
         ncheck++; if (ch_b !== 4'(ech)) $display("FAIL b_scan_ch cyc=%0d got %0d want %0d", c, ch_b, ech); else npass++;
         ncheck++; if (y_b !== 4'(ech + 1)) $display("FAIL b_scan_y cyc=%0d got %h want %h", c, y_b, ech + 1); else npass++;
         ncheck++; if (sd_b !== esd) $display("FAIL b_scan_sd cyc=%0d got %b want %b", c, sd_b, esd); else npass++;
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_inhibit();
      test_scan();
      test_freeze();
      test_async_reset();
      test_b_manual();
      test_b_mode_inhibit();
      test_b_scan();
      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
